assignment_receiver: RTL and testbench
======================================

Name: assignment_receiver

Overview:
- Receiving end of the nonogram assignment stream.
- Accepts 20-bit clue/assignment words, each tagged with a beat index, plus sending/done strobes, as produced by the ROM-backed registry.
- Stores the words in an on-chip row bank and validates ordering and count.
- Once a puzzle is fully loaded, serves registered random-access reads to the game/display logic.

Parameters:
- WORD_W, 20, width of one assignment word.
- IDX_W, 6, width of the incoming beat index.
- DEPTH, 20, rows in the bank; also the number of beats required for a complete load.
- ADDR_W, 5, width of the read address (must satisfy 2^ADDR_W >= DEPTH).

Ports:
- clk_in  input  1  system clock.
- reset_n_in  input  1  synchronous active-low reset.
- start_in  input  1  arm a new capture; clears the bank.
- assignment_in  input  WORD_W  incoming word.
- counter_in  input  IDX_W  beat index of assignment_in.
- sending_in  input  1  assignment_in/counter_in valid this cycle.
- done_in  input  1  transmitter end-of-stream strobe.
- read_addr_in  input  ADDR_W  row to read.
- row_out  output  WORD_W  registered read data.
- beats_out  output  IDX_W  valid beats accepted so far.
- busy_out  output  1  high in ARMED or CAPTURE.
- loaded_out  output  1  bank complete and valid.
- error_out  output  1  sticky protocol error.
- checksum_out  output  WORD_W  XOR of all accepted words.

Behaviour:
- Reset: all sampled on a rising clk_in edge with reset_n_in=0, which overrides all other inputs.
  - state=IDLE.
  - row_out, beats_out, checksum_out, all bank rows = 0.
  - busy_out, loaded_out, error_out = 0.
- Reset mid-capture abandons the capture with no partial loaded_out.
- States: IDLE, ARMED, CAPTURE, LOADED, ERROR.
- IDLE/LOADED/ERROR + start_in → ARMED, next cycle:
  - bank zeroed, beats_out=0, checksum_out=0.
  - loaded_out=0, error_out=0.
- start_in in ARMED/CAPTURE also restarts (same clear, state=ARMED). It takes priority over a same-cycle beat or done_in.
- ARMED: first cycle with sending_in=1 → CAPTURE, and that beat is processed as below. done_in while ARMED with no beats → ERROR.
- Beat processing (ARMED/CAPTURE, sending_in=1):
  - Expected index = beats_out.
  - If counter_in == beats_out and counter_in < DEPTH:
    - bank[counter_in] <= assignment_in.
    - beats_out++.
    - checksum_out ^= assignment_in.
  - Otherwise (skip, repeat, or index >= DEPTH) → ERROR; the word is not written.
- sending_in ignored in IDLE, LOADED, ERROR.
- done_in in CAPTURE:
  - Evaluated after any same-cycle beat, i.e. on the updated count.
  - Updated count == DEPTH → LOADED, loaded_out=1 next cycle.
  - Otherwise → ERROR.
- Beat count reaching DEPTH without done_in: stay in CAPTURE. Any further beat has index DEPTH and → ERROR.
- ERROR: error_out=1, loaded_out=0. Bank contents retained for debug. Exit only via start_in or reset.
- busy_out = (state==ARMED || state==CAPTURE), registered.
- Read port:
  - 1-cycle latency: row_out <= bank[read_addr_in] every cycle, in any state.
  - read_addr_in >= DEPTH → row_out <= 0.
  - A read of a row written in the same cycle returns the old value; new data appears one cycle later.
- Widths: beats_out saturates conceptually at DEPTH via the error rule and never wraps. checksum is pure XOR with no carry.

Test Plan:
- Nominal load: reset, start_in pulse, 20 beats of sending_in with counter_in 0..19 and assignment_in=0xA0000+i, done_in the cycle after beat 19 → loaded_out=1, beats_out=20, busy_out=0, checksum_out = XOR of the 20 words; read addr 7 → row_out=0xA0007 one cycle later; addr 25 → 0.
- done_in on same cycle as beat 19 → LOADED, identical bank and checksum to the nominal case.
- Out-of-order: indices 0,1,3 → error_out=1 on cycle after index 3, bank[3]=0, loaded_out=0; subsequent beats and done_in ignored.
- Early done: 12 valid beats then done_in → error_out=1, beats_out=12; start_in → error_out=0, bank rows all read 0, busy_out=1.
- Restart mid-capture: start_in while beat 5 arrives → beat dropped, beats_out=0, full 20-beat load then succeeds.
- Reset mid-capture: reset_n_in=0 for one cycle after beat 9 → all outputs 0, state IDLE; sending_in beats without start_in are ignored (beats_out stays 0).

Source files
------------

// File: rtl/assignment_receiver.sv
// Receiver for the nonogram assignment stream: captures indexed words into a row
// bank, checks ordering and count, then serves registered random-access reads.
module assignment_receiver #(
    parameter int WORD_W = 20,
    parameter int IDX_W  = 6,
    parameter int DEPTH  = 20,
    parameter int ADDR_W = 5
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              start_in,
    input  logic [WORD_W-1:0] assignment_in,
    input  logic [IDX_W-1:0]  counter_in,
    input  logic              sending_in,
    input  logic              done_in,
    input  logic [ADDR_W-1:0] read_addr_in,
    output logic [WORD_W-1:0] row_out,
    output logic [IDX_W-1:0]  beats_out,
    output logic              busy_out,
    output logic              loaded_out,
    output logic              error_out,
    output logic [WORD_W-1:0] checksum_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAPTURE = 3'd2,
        LOADED  = 3'd3,
        ERROR   = 3'd4
    } state_t;

    // One extra bit so DEPTH itself is representable for the range/count tests.
    localparam logic [IDX_W:0] DEPTH_IX = (IDX_W+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  bank_q [DEPTH];
    logic [WORD_W-1:0]  bank_d [DEPTH];
    logic [IDX_W-1:0]   beats_q, beats_d;
    logic [WORD_W-1:0]  checksum_q, checksum_d;
    logic [WORD_W-1:0]  row_q, row_d;
    logic               busy_q, busy_d;
    logic               loaded_q, loaded_d;
    logic               error_q, error_d;
    logic               clear;

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        checksum_d = checksum_q;
        bank_d     = bank_q;
        clear      = 1'b0;

        case (state_q)
            IDLE, LOADED, ERROR: begin
                if (start_in) clear = 1'b1;
            end
            ARMED, CAPTURE: begin
                if (start_in) begin
                    clear = 1'b1;
                end else begin
                    if (sending_in) begin
                        if ((counter_in == beats_q) && ({1'b0, counter_in} < DEPTH_IX)) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (counter_in == IDX_W'(i)) bank_d[i] = assignment_in;
                            end
                            beats_d    = beats_q + IDX_W'(1);
                            checksum_d = checksum_q ^ assignment_in;
                            state_d    = CAPTURE;
                        end else begin
                            state_d = ERROR;
                        end
                    end
                    // done_in judges the count including any beat taken this cycle.
                    if (done_in && (state_d != ERROR)) begin
                        state_d = ({1'b0, beats_d} == DEPTH_IX) ? LOADED : ERROR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear) begin
            state_d    = ARMED;
            beats_d    = '0;
            checksum_d = '0;
            for (int i = 0; i < DEPTH; i++) bank_d[i] = '0;
        end

        busy_d   = (state_d == ARMED) || (state_d == CAPTURE);
        loaded_d = (state_d == LOADED);
        error_d  = (state_d == ERROR);
    end

    // Read mux sees the pre-write bank, so a same-cycle write shows up one cycle later.
    always_comb begin
        row_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (read_addr_in == ADDR_W'(i)) row_d = bank_q[i];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state_q    <= IDLE;
            beats_q    <= '0;
            checksum_q <= '0;
            row_q      <= '0;
            busy_q     <= 1'b0;
            loaded_q   <= 1'b0;
            error_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            checksum_q <= checksum_d;
            row_q      <= row_d;
            busy_q     <= busy_d;
            loaded_q   <= loaded_d;
            error_q    <= error_d;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= bank_d[i];
        end
    end

    assign row_out      = row_q;
    assign beats_out    = beats_q;
    assign busy_out     = busy_q;
    assign loaded_out   = loaded_q;
    assign error_out    = error_q;
    assign checksum_out = checksum_q;

endmodule

// File: tb/tb_assignment_receiver.sv
// Scenario bench for assignment_receiver: expected read data queued when the
// address is driven and compared when the registered row appears.
module tb_assignment_receiver;

    localparam int WORD_W = 20;
    localparam int IDX_W  = 6;
    localparam int DEPTH  = 20;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset_n_in;
    logic              start_in;
    logic [WORD_W-1:0] assignment_in;
    logic [IDX_W-1:0]  counter_in;
    logic              sending_in;
    logic              done_in;
    logic [ADDR_W-1:0] read_addr_in;
    logic [WORD_W-1:0] row_out;
    logic [IDX_W-1:0]  beats_out;
    logic              busy_out;
    logic              loaded_out;
    logic              error_out;
    logic [WORD_W-1:0] checksum_out;

    int checks = 0;
    int errors = 0;
    logic [WORD_W-1:0] exp_q[$];
    logic [WORD_W-1:0] exp_row;

    always #5 clk = ~clk;

    assignment_receiver #(
        .WORD_W(WORD_W), .IDX_W(IDX_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_in(clk),
        .reset_n_in(reset_n_in),
        .start_in(start_in),
        .assignment_in(assignment_in),
        .counter_in(counter_in),
        .sending_in(sending_in),
        .done_in(done_in),
        .read_addr_in(read_addr_in),
        .row_out(row_out),
        .beats_out(beats_out),
        .busy_out(busy_out),
        .loaded_out(loaded_out),
        .error_out(error_out),
        .checksum_out(checksum_out)
    );

    function automatic logic [WORD_W-1:0] word_of(input logic [WORD_W-1:0] base, input int i);
        return base + WORD_W'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        step();
        start_in = 1'b0;
    endtask

    task automatic do_beat(input int idx, input logic [WORD_W-1:0] w, input logic done);
        sending_in    = 1'b1;
        counter_in    = IDX_W'(idx);
        assignment_in = w;
        done_in       = done;
        step();
        sending_in = 1'b0;
        done_in    = 1'b0;
    endtask

    task automatic do_done();
        done_in = 1'b1;
        step();
        done_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0; start_in = 1'b0; assignment_in = '0; counter_in = '0;
        sending_in = 1'b0; done_in = 1'b0; read_addr_in = '0;
        step(); step();
        reset_n_in = 1'b1;
        checks++;
        if ({row_out, beats_out, busy_out, loaded_out, error_out, checksum_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: row=%h beats=%0d busy=%b loaded=%b err=%b cks=%h, required all 0",
                     row_out, beats_out, busy_out, loaded_out, error_out, checksum_out);
        end
        read_addr_in = 5'd3;
        exp_q.push_back('0);
        step();
        exp_row = exp_q.pop_front();
        checks++;
        if (row_out !== exp_row) begin
            errors++;
            $display("FAIL reset_bank_row3: got %h, required %h", row_out, exp_row);
        end
    endtask

    task automatic test_nominal();
        logic [WORD_W-1:0] cks = '0;
        do_start();
        checks++;
        if (busy_out !== 1'b1 || beats_out !== '0 || loaded_out !== 1'b0) begin
            errors++;
            $display("FAIL nominal_armed: busy=%b beats=%0d loaded=%b, required 1/0/0", busy_out, beats_out, loaded_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            // Reading the row being written must still return the cleared value.
            read_addr_in = ADDR_W'(i);
            exp_q.push_back('0);
            cks ^= word_of(20'hA0000, i);
            do_beat(i, word_of(20'hA0000, i), 1'b0);
            exp_row = exp_q.pop_front();
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL nominal_rdw_row%0d: got %h, required %h", i, row_out, exp_row);
            end
        end
        checks++;
        if (beats_out !== IDX_W'(DEPTH) || busy_out !== 1'b1 || loaded_out !== 1'b0) begin
            errors++;
            $display("FAIL nominal_full_no_done: beats=%0d busy=%b loaded=%b, required 20/1/0", beats_out, busy_out, loaded_out);
        end
        do_done();
        checks++;
        if (loaded_out !== 1'b1 || beats_out !== IDX_W'(DEPTH) || busy_out !== 1'b0 ||
            error_out !== 1'b0 || checksum_out !== cks) begin
            errors++;
            $display("FAIL nominal_loaded: loaded=%b beats=%0d busy=%b err=%b cks=%h, required 1/20/0/0/%h",
                     loaded_out, beats_out, busy_out, error_out, checksum_out, cks);
        end
        for (int a = 0; a < 32; a++) begin
            read_addr_in = ADDR_W'(a);
            exp_q.push_back((a < DEPTH) ? word_of(20'hA0000, a) : '0);
            step();
            exp_row = exp_q.pop_front();
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL nominal_read_addr%0d: got %h, required %h", a, row_out, exp_row);
            end
        end
    endtask

    task automatic test_done_same_cycle();
        logic [WORD_W-1:0] cks = '0;
        do_start();
        for (int i = 0; i < DEPTH; i++) begin
            cks ^= word_of(20'hA0000, i);
            do_beat(i, word_of(20'hA0000, i), (i == DEPTH-1));
        end
        checks++;
        if (loaded_out !== 1'b1 || error_out !== 1'b0 || checksum_out !== cks || beats_out !== IDX_W'(DEPTH)) begin
            errors++;
            $display("FAIL same_cycle_done: loaded=%b err=%b cks=%h beats=%0d, required 1/0/%h/20",
                     loaded_out, error_out, checksum_out, beats_out, cks);
        end
        for (int a = 0; a < DEPTH; a += 6) begin
            read_addr_in = ADDR_W'(a);
            exp_q.push_back(word_of(20'hA0000, a));
            step();
            exp_row = exp_q.pop_front();
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL same_cycle_read%0d: got %h, required %h", a, row_out, exp_row);
            end
        end
    endtask

    task automatic test_out_of_order();
        do_start();
        do_beat(0, 20'h11111, 1'b0);
        do_beat(1, 20'h22222, 1'b0);
        do_beat(3, 20'h33333, 1'b0);
        checks++;
        if (error_out !== 1'b1 || loaded_out !== 1'b0 || busy_out !== 1'b0 || beats_out !== 6'd2 ||
            checksum_out !== (20'h11111 ^ 20'h22222)) begin
            errors++;
            $display("FAIL ooo_error: err=%b loaded=%b busy=%b beats=%0d cks=%h, required 1/0/0/2/%h",
                     error_out, loaded_out, busy_out, beats_out, checksum_out, 20'h11111 ^ 20'h22222);
        end
        do_beat(2, 20'h44444, 1'b0);
        do_done();
        checks++;
        if (error_out !== 1'b1 || loaded_out !== 1'b0 || beats_out !== 6'd2) begin
            errors++;
            $display("FAIL ooo_sticky: err=%b loaded=%b beats=%0d, required 1/0/2", error_out, loaded_out, beats_out);
        end
        read_addr_in = 5'd3;
        exp_q.push_back('0);
        step();
        read_addr_in = 5'd1;
        exp_q.push_back(20'h22222);
        exp_row = exp_q.pop_front();
        checks++;
        if (row_out !== exp_row) begin
            errors++;
            $display("FAIL ooo_row3: got %h, required %h", row_out, exp_row);
        end
        step();
        exp_row = exp_q.pop_front();
        checks++;
        if (row_out !== exp_row) begin
            errors++;
            $display("FAIL ooo_row1: got %h, required %h", row_out, exp_row);
        end
    endtask

    task automatic test_early_done();
        do_start();
        for (int i = 0; i < 12; i++) do_beat(i, word_of(20'h30000, i), 1'b0);
        do_done();
        checks++;
        if (error_out !== 1'b1 || beats_out !== 6'd12 || loaded_out !== 1'b0) begin
            errors++;
            $display("FAIL early_done: err=%b beats=%0d loaded=%b, required 1/12/0", error_out, beats_out, loaded_out);
        end
        do_start();
        checks++;
        if (error_out !== 1'b0 || busy_out !== 1'b1 || beats_out !== '0 || checksum_out !== '0) begin
            errors++;
            $display("FAIL early_restart: err=%b busy=%b beats=%0d cks=%h, required 0/1/0/0",
                     error_out, busy_out, beats_out, checksum_out);
        end
        for (int a = 0; a < DEPTH; a++) begin
            read_addr_in = ADDR_W'(a);
            exp_q.push_back('0);
            step();
            exp_row = exp_q.pop_front();
            checks++;
            if (row_out !== exp_row) begin
                errors++;
                $display("FAIL early_cleared_row%0d: got %h, required %h", a, row_out, exp_row);
            end
        end
        // Lone done while armed with no beats is an error.
        do_done();
        checks++;
        if (error_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL armed_done: err=%b busy=%b, required 1/0", error_out, busy_out);
        end
    endtask

    task automatic test_overflow();
        do_start();
        for (int i = 0; i < DEPTH; i++) do_beat(i, word_of(20'h60000, i), 1'b0);
        do_beat(DEPTH, 20'hFFFFF, 1'b0);
        checks++;
        if (error_out !== 1'b1 || beats_out !== IDX_W'(DEPTH) || loaded_out !== 1'b0) begin
            errors++;
            $display("FAIL overflow_beat: err=%b beats=%0d loaded=%b, required 1/20/0", error_out, beats_out, loaded_out);
        end
    endtask

    task automatic test_restart_mid();
        logic [WORD_W-1:0] cks = '0;
        do_start();
        for (int i = 0; i < 5; i++) do_beat(i, word_of(20'h50000, i), 1'b0);
        start_in = 1'b1;
        do_beat(5, word_of(20'h50000, 5), 1'b0);
        start_in = 1'b0;
        checks++;
        if (beats_out !== '0 || busy_out !== 1'b1 || checksum_out !== '0 || error_out !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: beats=%0d busy=%b cks=%h err=%b, required 0/1/0/0",
                     beats_out, busy_out, checksum_out, error_out);
        end
        for (int i = 0; i < DEPTH; i++) begin
            cks ^= word_of(20'h70000, 3*i);
            do_beat(i, word_of(20'h70000, 3*i), 1'b0);
        end
        do_done();
        checks++;
        if (loaded_out !== 1'b1 || checksum_out !== cks) begin
            errors++;
            $display("FAIL restart_reload: loaded=%b cks=%h, required 1/%h", loaded_out, checksum_out, cks);
        end
        read_addr_in = 5'd5;
        exp_q.push_back(word_of(20'h70000, 15));
        step();
        exp_row = exp_q.pop_front();
        checks++;
        if (row_out !== exp_row) begin
            errors++;
            $display("FAIL restart_row5: got %h, required %h", row_out, exp_row);
        end
    endtask

    task automatic test_reset_mid();
        do_start();
        for (int i = 0; i < 10; i++) do_beat(i, word_of(20'h80000, i), 1'b0);
        read_addr_in = 5'd2;
        reset_n_in = 1'b0;
        step();
        reset_n_in = 1'b1;
        checks++;
        if ({row_out, beats_out, busy_out, loaded_out, error_out, checksum_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid: row=%h beats=%0d busy=%b loaded=%b err=%b cks=%h, required all 0",
                     row_out, beats_out, busy_out, loaded_out, error_out, checksum_out);
        end
        for (int i = 0; i < 4; i++) do_beat(i, word_of(20'h90000, i), (i == 3));
        checks++;
        if (beats_out !== '0 || busy_out !== 1'b0 || loaded_out !== 1'b0 || error_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: beats=%0d busy=%b loaded=%b err=%b, required 0/0/0/0",
                     beats_out, busy_out, loaded_out, error_out);
        end
        exp_q.push_back('0);
        step();
        exp_row = exp_q.pop_front();
        checks++;
        if (row_out !== exp_row) begin
            errors++;
            $display("FAIL reset_mid_row2: got %h, required %h", row_out, exp_row);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_done_same_cycle();
        test_out_of_order();
        test_early_done();
        test_overflow();
        test_restart_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
